// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: line-decoder states, word geometry and default
// timing (clk cycles at 10 MHz), used by both receiver and transmitter.
package ws2812_pkg;

    localparam int unsigned WORD_BITS           = 24;
    localparam int unsigned BIT_CNT_W           = 5;
    localparam int unsigned WORD_CNT_W          = 8;
    localparam int unsigned DEF_SAMPLE_CYCLES   = 6;
    localparam int unsigned DEF_MIN_HIGH_CYCLES = 2;
    localparam int unsigned DEF_RESET_CYCLES    = 500;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } ws2812_state_t;

    // One pixel as it travels on the wire: green first, blue last.
    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

endpackage

// File: rtl/ws2812_rx_sync.sv
// Two-flop synchroniser for the asynchronous WS2812 line plus rising/falling
// edge detection on the synchronised value.
module ws2812_rx_sync (
    input  logic clk,
    input  logic resetb,
    input  logic din,
    output logic din_s,
    output logic rise_c,
    output logic fall_c
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign din_s  = sync_q;
    assign rise_c = sync_q & ~prev_q;
    assign fall_c = ~sync_q & prev_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 serial receiver: pulse-width decodes the line into 24-bit GRB words
// with valid/ready handoff and frame detection. Define WS2812_RX_FORWARD_EN to
// add the chain-pixel dout that repeats the line after the first word.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int unsigned SAMPLE_CYCLES   = DEF_SAMPLE_CYCLES,
    parameter int unsigned MIN_HIGH_CYCLES = DEF_MIN_HIGH_CYCLES,
    parameter int unsigned RESET_CYCLES    = DEF_RESET_CYCLES
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  din,
    output logic [WORD_BITS-1:0]  data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  frame_o,
    output logic [WORD_CNT_W-1:0] word_cnt_o,
    output logic                  overrun_o
`ifdef WS2812_RX_FORWARD_EN
    ,
    output logic                  dout
`endif
);

    localparam int unsigned HCW = $clog2(SAMPLE_CYCLES + 1) + 1;
    localparam int unsigned LCW = $clog2(RESET_CYCLES + 1);

    localparam logic [HCW-1:0]        HIGH_MAX  = '1;
    localparam logic [HCW-1:0]        SAMPLE_TH = HCW'(SAMPLE_CYCLES);
    localparam logic [HCW-1:0]        MIN_TH    = HCW'(MIN_HIGH_CYCLES);
    localparam logic [LCW-1:0]        LOW_TH    = LCW'(RESET_CYCLES - 1);
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(WORD_BITS - 1);
    localparam logic [WORD_CNT_W-1:0] WCNT_MAX  = '1;

    logic din_s;
    logic rise_c;
    logic fall_c;

    ws2812_state_t state_q;
    ws2812_state_t state_nxt;

    logic [HCW-1:0]       high_cnt_q;
    logic [LCW-1:0]       low_cnt_q;
    logic [WORD_BITS-1:0] shreg_q;
    logic [BIT_CNT_W-1:0] bit_cnt_q;

    logic                 enter_high_c;
    logic                 enter_low_c;
    logic                 bit_acc_c;
    logic                 bit_val_c;
    logic                 frame_end_c;
    logic                 word_done_c;
    logic [WORD_BITS-1:0] word_nxt_c;

    ws2812_rx_sync u_sync (
        .clk    (clk),
        .resetb (resetb),
        .din    (din),
        .din_s  (din_s),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Line state machine; a bit is judged at the end of its high pulse.
    always_comb begin
        state_nxt   = state_q;
        bit_acc_c   = 1'b0;
        bit_val_c   = 1'b0;
        frame_end_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise_c) begin
                    state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (fall_c) begin
                    state_nxt = ST_LOW;
                    if (high_cnt_q >= MIN_TH) begin
                        bit_acc_c = 1'b1;
                        bit_val_c = (high_cnt_q >= SAMPLE_TH);
                    end
                end
            end
            ST_LOW: begin
                if (rise_c) begin
                    state_nxt = ST_HIGH;
                end else if (low_cnt_q >= LOW_TH) begin
                    state_nxt   = ST_IDLE;
                    frame_end_c = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        enter_high_c = (state_nxt == ST_HIGH) && (state_q != ST_HIGH);
        enter_low_c  = (state_nxt == ST_LOW) && (state_q != ST_LOW);
        word_done_c  = bit_acc_c && (bit_cnt_q == LAST_BIT);
        word_nxt_c   = {shreg_q[WORD_BITS-2:0], bit_val_c};
    end

    // Width counters restart at 1 because the edge cycle is the first sample.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
        end else begin
            if (enter_high_c) begin
                high_cnt_q <= HCW'(1);
            end else if ((state_q == ST_HIGH) && (high_cnt_q != HIGH_MAX)) begin
                high_cnt_q <= high_cnt_q + HCW'(1);
            end
            if (enter_low_c) begin
                low_cnt_q <= LCW'(1);
            end else if ((state_q == ST_LOW) && (low_cnt_q < LOW_TH)) begin
                low_cnt_q <= low_cnt_q + LCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            word_cnt_o <= '0;
        end else if (frame_end_c) begin
            bit_cnt_q  <= '0;
            word_cnt_o <= '0;
        end else if (bit_acc_c) begin
            shreg_q <= word_nxt_c;
            if (word_done_c) begin
                bit_cnt_q <= '0;
                if (word_cnt_o != WCNT_MAX) begin
                    word_cnt_o <= word_cnt_o + WORD_CNT_W'(1);
                end
            end else begin
                bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
            end
        end
    end

    // Output handoff: a completed word is dropped only if the held one is not taken.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            data_o    <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
            frame_o   <= 1'b0;
        end else begin
            frame_o <= frame_end_c;
            if (word_done_c && (!valid_o || ready_i)) begin
                data_o  <= word_nxt_c;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            if (word_done_c && valid_o && !ready_i) begin
                overrun_o <= 1'b1;
            end
        end
    end

`ifdef WS2812_RX_FORWARD_EN
    logic fwd_q;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            fwd_q <= 1'b0;
        end else if (frame_end_c) begin
            fwd_q <= 1'b0;
        end else if (word_done_c) begin
            fwd_q <= 1'b1;
        end
    end

    // Gate the synchronised line directly so downstream sees only the sync latency.
    assign dout = fwd_q & din_s;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: directed waveforms push expected words, a
// monitor pops and compares on every accepted output word.
`timescale 1ns/1ps
module tb_ws2812_rx;

    logic        clk = 1'b0;
    logic        resetb;
    logic        din;
    logic        ready_i;
    logic [23:0] data_o;
    logic        valid_o;
    logic        frame_o;
    logic [7:0]  word_cnt_o;
    logic        overrun_o;
`ifdef WS2812_RX_FORWARD_EN
    logic        dout;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          frame_seen = 0;
    int          f0;
    bit          mon_pending = 1'b0;
    logic [23:0] sb[$];

    always #5 clk = ~clk;

    ws2812_rx dut (
`ifdef WS2812_RX_FORWARD_EN
        .dout       (dout),
`endif
        .clk        (clk),
        .resetb     (resetb),
        .din        (din),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .frame_o    (frame_o),
        .word_cnt_o (word_cnt_o),
        .overrun_o  (overrun_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // bit 1: 8 high / 4 low, bit 0: 4 high / 8 low; optional 1-cycle glitch in the low time
    task automatic send_bit(input bit b, input bit glitch);
        din = 1'b1;
        tick(b ? 8 : 4);
        din = 1'b0;
        if (glitch) begin
            tick(2);
            din = 1'b1;
            tick(1);
            din = 1'b0;
            tick(b ? 1 : 5);
        end else begin
            tick(b ? 4 : 8);
        end
    endtask

    task automatic send_bits(input logic [23:0] w, input int n, input bit glitch);
        logic [23:0] v;
        v = w;
        for (int i = 0; i < n; i++) begin
            send_bit(v[23-i], glitch);
        end
    endtask

    task automatic send_word(input logic [23:0] w, input bit glitch);
        send_bits(w, 24, glitch);
    endtask

    // Monitor: every accepted word must match the scoreboard head and drop next cycle
    initial begin
        logic [23:0] exp;
        forever begin
            @(negedge clk);
            if (mon_pending) begin
                check("valid_one_cycle", 32'(valid_o), 32'h0);
                mon_pending = 1'b0;
            end
            if (resetb === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%06h, scoreboard empty", data_o);
                end else begin
                    exp = sb.pop_front();
                    check("word", 32'(data_o), 32'(exp));
                end
                mon_pending = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (frame_o === 1'b1) frame_seen++;
        end
    end

`ifdef WS2812_RX_FORWARD_EN
    bit   fwd_zero   = 1'b0;
    bit   fwd_follow = 1'b0;
    int   fwd_err    = 0;
    logic d1 = 1'b0;
    logic d2 = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (fwd_zero && dout !== 1'b0) fwd_err++;
            if (fwd_follow && dout !== d2) fwd_err++;
            d2 = d1;
            d1 = din;
        end
    end
`endif

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: bench exceeded 60000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        resetb  = 1'b0;
        din     = 1'b0;
        ready_i = 1'b1;
        tick(3);
        check("rst_data", 32'(data_o), 32'h0);
        check("rst_valid", 32'(valid_o), 32'h0);
        check("rst_frame", 32'(frame_o), 32'h0);
        check("rst_wcnt", 32'(word_cnt_o), 32'h0);
        check("rst_overrun", 32'(overrun_o), 32'h0);
        resetb = 1'b1;
        tick(5);

        // single word, consumer always ready
        f0 = frame_seen;
        sb.push_back(24'hFF0055);
        send_word(24'hFF0055, 1'b0);
        tick(2);
        check("t1_wcnt", 32'(word_cnt_o), 32'd1);
        check("t1_data", 32'(data_o), 32'hFF0055);
        tick(520);
        check("t1_frame", 32'(frame_seen - f0), 32'd1);

        // two words then end of frame
        f0 = frame_seen;
        sb.push_back(24'h0F0F0F);
        sb.push_back(24'hF0C3A5);
        send_word(24'h0F0F0F, 1'b0);
        send_word(24'hF0C3A5, 1'b0);
        tick(2);
        check("t2_wcnt2", 32'(word_cnt_o), 32'd2);
        tick(520);
        check("t2_frame", 32'(frame_seen - f0), 32'd1);
        check("t2_wcnt0", 32'(word_cnt_o), 32'd0);
        tick(100);
        check("t2_frame_once", 32'(frame_seen - f0), 32'd1);

        // overrun: second word dropped while first is unconsumed
        ready_i = 1'b0;
        sb.push_back(24'h000001);
        send_word(24'h000001, 1'b0);
        send_word(24'h800000, 1'b0);
        tick(2);
        check("t3_data", 32'(data_o), 32'h000001);
        check("t3_valid", 32'(valid_o), 32'h1);
        check("t3_overrun", 32'(overrun_o), 32'h1);
        ready_i = 1'b1;
        tick(3);
        check("t3_valid_drop", 32'(valid_o), 32'h0);
        tick(520);

        // glitches between bits are discarded
        sb.push_back(24'hA5A5A5);
        send_word(24'hA5A5A5, 1'b1);
        tick(2);
        check("t4_data", 32'(data_o), 32'hA5A5A5);
        tick(520);

        // partial word discarded at frame end
        send_bits(24'hFFFFFF, 10, 1'b0);
        tick(520);
        sb.push_back(24'h123456);
        send_word(24'h123456, 1'b0);
        tick(2);
        check("t5_wcnt", 32'(word_cnt_o), 32'd1);
        check("t5_data", 32'(data_o), 32'h123456);
        check("t5_overrun_sticky", 32'(overrun_o), 32'h1);

        // reset in the middle of a word
        send_bits(24'h3C3C3C, 12, 1'b0);
        din = 1'b1;
        tick(3);
        resetb = 1'b0;
        din    = 1'b0;
        tick(2);
        check("t6_rst_data", 32'(data_o), 32'h0);
        check("t6_rst_valid", 32'(valid_o), 32'h0);
        check("t6_rst_frame", 32'(frame_o), 32'h0);
        check("t6_rst_wcnt", 32'(word_cnt_o), 32'h0);
        check("t6_rst_overrun", 32'(overrun_o), 32'h0);
`ifdef WS2812_RX_FORWARD_EN
        check("t6_rst_dout", 32'(dout), 32'h0);
`endif
        resetb = 1'b1;
        tick(5);
        sb.push_back(24'h654321);
        send_word(24'h654321, 1'b0);
        tick(2);
        check("t6_data", 32'(data_o), 32'h654321);
        tick(520);

        // stuck-high line counts as one long 1 bit, no wrap
        sb.push_back(24'h80ABCD);
        din = 1'b1;
        tick(305);
        din = 1'b0;
        tick(8);
        send_bits(24'h01579A, 23, 1'b0);
        tick(2);
        check("t7_data", 32'(data_o), 32'h80ABCD);
        check("t7_wcnt", 32'(word_cnt_o), 32'd1);
        tick(520);

`ifdef WS2812_RX_FORWARD_EN
        // chain forwarding: quiet during word 1, then line copy
        sb.push_back(24'hC0FFEE);
        sb.push_back(24'h5A5A5A);
        sb.push_back(24'h13579B);
        fwd_zero = 1'b1;
        send_word(24'hC0FFEE, 1'b0);
        fwd_zero   = 1'b0;
        fwd_follow = 1'b1;
        send_word(24'h5A5A5A, 1'b0);
        send_word(24'h13579B, 1'b0);
        tick(20);
        fwd_follow = 1'b0;
        tick(520);
        fwd_zero = 1'b1;
        tick(20);
        fwd_zero = 1'b0;
        check("fwd_errors", 32'(fwd_err), 32'd0);
`endif

        tick(10);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ws2812_rx.md
WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 SHALL have parameter SAMPLE_CYCLES, default 6, high-pulse width in clk cycles at or above which a bit decodes as 1.
REQ-002 SHALL have parameter MIN_HIGH_CYCLES, default 2, high-pulse width below which a pulse is a glitch and is discarded.
REQ-003 SHALL have parameter RESET_CYCLES, default 500, low-time in clk cycles that marks end of frame (50 us at 10 MHz).
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port resetb, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port din, input, 1, asynchronous WS2812 serial line.
REQ-007 SHALL have port data_o, output, 24, last decoded GRB word, MSB first on the wire.
REQ-008 SHALL have port valid_o, output, 1, data_o holds an unconsumed word.
REQ-009 SHALL have port ready_i, input, 1, consumer accepts data_o.
REQ-010 SHALL have port frame_o, output, 1, one-cycle pulse at end-of-frame detection.
REQ-011 SHALL have port word_cnt_o, output, 8, words completed in current frame, saturating at 255.
REQ-012 SHALL have port overrun_o, output, 1, sticky flag: a word completed while valid_o was high and ready_i low.
REQ-013 SHALL have port dout, output, 1, downstream line; present only per REQ-030.

Function
REQ-014 SHALL synchronise din through two flops; all decoding uses the synchronised value (2-cycle input latency).
REQ-015 SHALL implement states IDLE, HIGH, LOW; IDLE->HIGH on synced rising edge; HIGH->LOW on falling edge; LOW->HIGH on rising edge; LOW->IDLE when low count reaches RESET_CYCLES.
REQ-016 SHALL count high-pulse width in a saturating counter cleared on entry to HIGH.
REQ-017 SHALL, on HIGH->LOW, discard the pulse if width < MIN_HIGH_CYCLES, else shift in 1 if width >= SAMPLE_CYCLES, else 0.
REQ-018 SHALL maintain a 5-bit bit counter; on the 24th accepted bit, load data_o and assert valid_o in the next cycle, clear bit counter, increment word_cnt_o.
REQ-019 SHALL deassert valid_o on the cycle after valid_o && ready_i is sampled high.
REQ-020 SHALL, if a word completes while valid_o=1 and ready_i=0, drop the new word, keep data_o, set overrun_o; simultaneous ready_i high in that cycle counts as accepted and the new word loads.
REQ-021 SHALL, on LOW->IDLE, pulse frame_o one cycle, discard partial bits, clear bit counter and word_cnt_o; valid_o and data_o unaffected.
REQ-022 SHALL treat a line stuck high as one pulse; counter saturation shall not wrap or emit bits.
REQ-023 SHALL hold frame_o low in IDLE after the pulse; no repeated pulses while line stays low.

Reset
REQ-024 SHALL, while resetb=0, force state IDLE, synchroniser flops 0, data_o=0, valid_o=0, frame_o=0, word_cnt_o=0, overrun_o=0, dout=0.
REQ-025 SHALL, on reset mid-word, discard partial bits; first post-reset frame decodes from bit 0.
REQ-026 SHALL clear overrun_o only by reset.

Configuration
REQ-027 SHALL support macro WS2812_RX_FORWARD_EN.
REQ-028 SHALL, with WS2812_RX_FORWARD_EN defined, behave as a chain pixel: after the first word of a frame, dout follows synchronised din; dout=0 during first word and after frame end.
REQ-029 SHALL, with forwarding, still decode and present every word on data_o.
REQ-030 SHALL, without WS2812_RX_FORWARD_EN, omit port dout and forwarding logic entirely.

Structure
REQ-031 SHALL place state enum, WORD_BITS=24 and default timing constants in shared package ws2812_pkg, reused by the transmitter.
REQ-032 SHALL isolate the two-flop synchroniser plus edge detector as sub-module ws2812_rx_sync.

Verification (defaults, 10 MHz)
REQ-033 Bench SHALL send 0xFF0055 (bit1: 8 high/4 low; bit0: 4 high/8 low), ready_i=1 -> data_o=0xFF0055, valid_o one cycle, word_cnt_o=1.
REQ-034 Bench SHALL send two words then 520 low cycles -> frame_o one pulse, word_cnt_o returns 0.
REQ-035 Bench SHALL send 0x000001 then 0x800000 with ready_i=0 -> data_o=0x000001, overrun_o=1.
REQ-036 Bench SHALL inject 1-cycle high glitches between bits of 0xA5A5A5 -> data_o=0xA5A5A5.
REQ-037 Bench SHALL send 10 bits, 520 low, then 0x123456 -> data_o=0x123456; assert resetb mid-word -> all outputs 0 per REQ-024.
REQ-038 Bench SHALL, with WS2812_RX_FORWARD_EN, send 3 words -> dout low during word 1, copies words 2-3 delayed 2 cycles.
